// File: rtl/alu_dispatch.sv
// Issue/retire stage around the ALU: queues CU operations, launches the head on
// ALU phase 01 and turns the ALU result into a writeback, branch or error pulse.
module alu_dispatch #(
  parameter int DEPTH = 4,
  parameter int RD_W  = 5
) (
  input  logic                     soc_clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               in_op,
  input  logic [31:0]              in_rs1_val,
  input  logic [31:0]              in_rs2_val,
  input  logic [RD_W-1:0]          in_rd,
  output logic [31:0]              ALU_dat1,
  output logic [31:0]              ALU_dat2,
  output logic [5:0]               Instruction_from_CU,
  input  logic [1:0]               ALU_result_counter,
  input  logic                     ALU_ready,
  input  logic [31:0]              ALU_out,
  input  logic                     ALU_con_met,
  input  logic                     ALU_overflow,
  output logic                     wb_valid,
  output logic                     wb_we,
  output logic [RD_W-1:0]          wb_rd,
  output logic [31:0]              wb_data,
  output logic                     wb_ovf,
  output logic                     br_valid,
  output logic                     br_taken,
  output logic                     err_unsupported,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_WRITE  = 2'd1,
    CLS_BRANCH = 2'd2
  } op_class_e;

  function automatic op_class_e classify(input logic [5:0] op);
    if (op >= 6'd4 && op <= 6'd9) return CLS_BRANCH;
    if (op == 6'd18 || op == 6'd19 || (op >= 6'd21 && op <= 6'd36)) return CLS_WRITE;
    return CLS_NONE;
  endfunction

  logic [5:0]      op_mem  [DEPTH];
  logic [31:0]     rs1_mem [DEPTH];
  logic [31:0]     rs2_mem [DEPTH];
  logic [RD_W-1:0] rd_mem  [DEPTH];

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            inflight_valid;
  logic [RD_W-1:0] inflight_rd;
  op_class_e       inflight_cls;

  logic            not_empty;
  logic            push;
  logic            launch;
  logic            complete;

  assign not_empty = (count != '0);
  assign in_ready  = (count < DEPTH_C);
  assign push      = in_valid && in_ready && !flush;
  assign launch    = (ALU_result_counter == 2'b01) && not_empty && !flush;
  assign complete  = ALU_ready && inflight_valid && !flush;
  assign busy      = not_empty || inflight_valid;

  // An empty queue presents opcode 0, which the ALU executes as a NOP.
  assign ALU_dat1            = not_empty ? rs1_mem[rd_ptr] : 32'd0;
  assign ALU_dat2            = not_empty ? rs2_mem[rd_ptr] : 32'd0;
  assign Instruction_from_CU = not_empty ? op_mem[rd_ptr]  : 6'd0;

  always_ff @(posedge soc_clk) begin
    if (push) begin
      op_mem[wr_ptr]  <= in_op;
      rs1_mem[wr_ptr] <= in_rs1_val;
      rs2_mem[wr_ptr] <= in_rs2_val;
      rd_mem[wr_ptr]  <= in_rd;
    end
  end

  always_ff @(posedge soc_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      inflight_valid  <= 1'b0;
      inflight_rd     <= '0;
      inflight_cls    <= CLS_NONE;
      wb_valid        <= 1'b0;
      wb_we           <= 1'b0;
      wb_rd           <= '0;
      wb_data         <= '0;
      wb_ovf          <= 1'b0;
      br_valid        <= 1'b0;
      br_taken        <= 1'b0;
      err_unsupported <= 1'b0;
    end else begin
      wb_valid        <= 1'b0;
      wb_we           <= 1'b0;
      wb_ovf          <= 1'b0;
      br_valid        <= 1'b0;
      br_taken        <= 1'b0;
      err_unsupported <= 1'b0;
      if (flush) begin
        wr_ptr         <= '0;
        rd_ptr         <= '0;
        count          <= '0;
        inflight_valid <= 1'b0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + 1'b1;
        if (launch) rd_ptr <= rd_ptr + 1'b1;
        if (push && !launch)      count <= count + 1'b1;
        else if (launch && !push) count <= count - 1'b1;

        if (complete) begin
          case (inflight_cls)
            CLS_WRITE: begin
              wb_valid <= 1'b1;
              wb_rd    <= inflight_rd;
              wb_data  <= ALU_out;
              wb_we    <= (inflight_rd != '0);
              wb_ovf   <= ALU_overflow;
            end
            CLS_BRANCH: begin
              br_valid <= 1'b1;
              br_taken <= ALU_con_met;
            end
            default: err_unsupported <= 1'b1;
          endcase
        end

        // Launch and completion fall on different ALU phases; launch wins if a
        // misbehaving ALU ever lines them up.
        if (launch) begin
          inflight_valid <= 1'b1;
          inflight_rd    <= rd_mem[rd_ptr];
          inflight_cls   <= classify(op_mem[rd_ptr]);
        end else if (complete) begin
          inflight_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch with a behavioural 4-phase ALU that samples
// its operands on phase 01 and returns a one-cycle result two edges later.
module tb_alu_dispatch;
  localparam int DEPTH = 4;
  localparam int RD_W  = 5;

  logic              soc_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [5:0]        in_op = '0;
  logic [31:0]       in_rs1_val = '0;
  logic [31:0]       in_rs2_val = '0;
  logic [RD_W-1:0]   in_rd = '0;
  logic [31:0]       ALU_dat1, ALU_dat2;
  logic [5:0]        Instruction_from_CU;
  logic [1:0]        ALU_result_counter;
  logic              ALU_ready = 1'b0;
  logic [31:0]       ALU_out = '0;
  logic              ALU_con_met = 1'b0;
  logic              ALU_overflow = 1'b0;
  logic              wb_valid, wb_we, wb_ovf, br_valid, br_taken, err_unsupported, busy;
  logic [RD_W-1:0]   wb_rd;
  logic [31:0]       wb_data;
  logic [$clog2(DEPTH):0] count;

  alu_dispatch #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .soc_clk(soc_clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_rd(in_rd),
    .ALU_dat1(ALU_dat1), .ALU_dat2(ALU_dat2), .Instruction_from_CU(Instruction_from_CU),
    .ALU_result_counter(ALU_result_counter), .ALU_ready(ALU_ready), .ALU_out(ALU_out),
    .ALU_con_met(ALU_con_met), .ALU_overflow(ALU_overflow),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ovf(wb_ovf),
    .br_valid(br_valid), .br_taken(br_taken), .err_unsupported(err_unsupported),
    .count(count), .busy(busy)
  );

  always #5 soc_clk = ~soc_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_strobes = 0;
  int last_cyc = -1;
  bit spacing_on = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ALU model: {con_met, overflow, result}
  function automatic logic [33:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    logic ovf, con;
    s = a + b; ovf = 1'b0; con = 1'b0;
    case (op)
      6'd18, 6'd27: ovf = (a[31] == b[31]) && (s[31] != a[31]);
      6'd4: begin con = (a == b); s = a - b; end
      6'd5: begin con = (a != b); s = a - b; end
      default: s = a ^ b;
    endcase
    return {con, ovf, s};
  endfunction

  // Retire kind: 001 writeback, 010 branch, 100 unsupported
  function automatic logic [2:0] kind_of(input logic [5:0] op);
    if (op inside {[6'd4:6'd9]}) return 3'b010;
    if (op inside {6'd18, 6'd19, [6'd21:6'd36]}) return 3'b001;
    return 3'b100;
  endfunction

  logic [1:0]  phase = 2'd0;
  logic        s1_v = 1'b0, s2_v = 1'b0;
  logic [5:0]  s1_op = '0, s2_op = '0;
  logic [31:0] s1_a = '0, s1_b = '0, s2_a = '0, s2_b = '0;
  logic [33:0] s2_res;
  assign ALU_result_counter = phase;
  assign s2_res = alu_fn(s2_op, s2_a, s2_b);

  always @(posedge soc_clk) begin
    phase        <= phase + 2'd1;
    s1_v         <= (phase == 2'b01);
    s1_op        <= Instruction_from_CU;
    s1_a         <= ALU_dat1;
    s1_b         <= ALU_dat2;
    s2_v         <= s1_v;
    s2_op        <= s1_op;
    s2_a         <= s1_a;
    s2_b         <= s1_b;
    ALU_ready    <= s2_v;
    ALU_out      <= s2_res[31:0];
    ALU_overflow <= s2_res[32];
    ALU_con_met  <= s2_res[33];
    cyc          <= cyc + 1;
  end

  typedef struct {
    logic [2:0]      kind;
    logic [RD_W-1:0] rd;
    logic [31:0]     data;
    logic            we;
    logic            ovf;
    logic            taken;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge soc_clk) begin : monitor
    exp_t e;
    logic [2:0] obs;
    if (reset_n) begin
      obs = {err_unsupported, br_valid, wb_valid};
      if (obs != 3'b000) begin
        n_strobes++;
        if (exp_q.size() == 0) begin
          check_val("unexpected_strobe", {29'd0, obs}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("kind", {29'd0, obs}, {29'd0, e.kind});
          if (e.kind == 3'b001) begin
            check_val("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
            check_val("wb_data", wb_data, e.data);
            check_val("wb_we", {31'd0, wb_we}, {31'd0, e.we});
            check_val("wb_ovf", {31'd0, wb_ovf}, {31'd0, e.ovf});
          end else if (e.kind == 3'b010) begin
            check_val("br_taken", {31'd0, br_taken}, {31'd0, e.taken});
          end
          if (spacing_on && last_cyc >= 0) check_val("spacing", cyc - last_cyc, 32'd4);
          last_cyc = cyc;
        end
      end
    end
  end

  task automatic push_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [RD_W-1:0] rd);
    exp_t e;
    logic [33:0] r;
    int guard = 0;
    in_op = op; in_rs1_val = a; in_rs2_val = b; in_rd = rd; in_valid = 1'b1;
    while (!in_ready && guard < 40) begin
      @(negedge soc_clk);
      guard++;
    end
    if (!in_ready) begin
      check_val("push_ready", {31'd0, in_ready}, 32'd1);
    end else begin
      r = alu_fn(op, a, b);
      e.kind = kind_of(op); e.rd = rd; e.data = r[31:0];
      e.we = (rd != 0); e.ovf = r[32]; e.taken = r[33];
      exp_q.push_back(e);
      @(posedge soc_clk);
    end
    @(negedge soc_clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_phase01();
    int guard = 0;
    while (ALU_result_counter != 2'b01 && guard < 8) begin
      @(negedge soc_clk);
      guard++;
    end
  endtask

  task automatic wait_drain(input string tag);
    int guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 60) begin
      @(negedge soc_clk);
      guard++;
    end
    check_val({tag, "_pending"}, exp_q.size(), 32'd0);
    repeat (3) @(negedge soc_clk);
    check_val({tag, "_count"}, {29'd0, count}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int strobes_before;
    int guard;

    repeat (3) @(negedge soc_clk);
    check_val("rst_count", {29'd0, count}, 32'd0);
    check_val("rst_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_strobes", {29'd0, err_unsupported, br_valid, wb_valid}, 32'd0);
    check_val("rst_instr", {26'd0, Instruction_from_CU}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge soc_clk);

    // Single ADD, head is presented to the ALU before launch
    push_op(6'd27, 32'd5, 32'd7, 5'd3);
    check_val("head_dat1", ALU_dat1, 32'd5);
    check_val("head_dat2", ALU_dat2, 32'd7);
    check_val("head_op", {26'd0, Instruction_from_CU}, 32'd27);
    check_val("one_count", {29'd0, count}, 32'd1);
    wait_drain("add");

    // Fill to DEPTH starting on a phase-01 edge with an empty queue
    wait_phase01();
    for (int i = 0; i < 4; i++) push_op(6'd27, i, 10 * i, 5'(i + 1));
    check_val("full_count", {29'd0, count}, 32'd4);
    check_val("full_ready", {31'd0, in_ready}, 32'd0);
    spacing_on = 1'b1;
    last_cyc = -1;
    push_op(6'd21, 32'hF0F0_0000, 32'h0000_0F0F, 5'd9);
    wait_drain("burst");
    spacing_on = 1'b0;

    push_op(6'd4, 32'h55, 32'h55, 5'd7);
    push_op(6'd5, 32'h55, 32'h55, 5'd8);
    wait_drain("branch");

    push_op(6'd18, 32'd1, 32'd1, 5'd0);
    push_op(6'd27, 32'h7FFF_FFFF, 32'd1, 5'd4);
    wait_drain("ovf");

    push_op(6'd20, 32'd3, 32'd4, 5'd9);
    wait_drain("unsup");

    // Flush one cycle before ALU_ready, with a second op still queued
    wait_phase01();
    push_op(6'd27, 32'd1, 32'd2, 5'd5);
    push_op(6'd27, 32'd3, 32'd4, 5'd6);
    guard = 0;
    while (count != 1 && guard < 10) begin
      @(negedge soc_clk);
      guard++;
    end
    check_val("flush_launched", {29'd0, count}, 32'd1);
    @(negedge soc_clk);
    strobes_before = n_strobes;
    exp_q.delete();
    flush = 1'b1;
    @(negedge soc_clk);
    flush = 1'b0;
    check_val("flush_count", {29'd0, count}, 32'd0);
    check_val("flush_busy", {31'd0, busy}, 32'd0);
    repeat (8) @(negedge soc_clk);
    check_val("flush_no_strobe", n_strobes - strobes_before, 32'd0);
    push_op(6'd27, 32'd100, 32'd23, 5'd11);
    wait_drain("post_flush");

    // Reset while a writeback strobe is high and a second op is queued
    wait_phase01();
    push_op(6'd27, 32'd10, 32'd20, 5'd2);
    push_op(6'd27, 32'd1, 32'd1, 5'd3);
    guard = 0;
    do begin
      @(posedge soc_clk);
      #1;
      guard++;
    end while (!wb_valid && guard < 20);
    check_val("pre_rst_wb", {31'd0, wb_valid}, 32'd1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_val("mid_rst_wb", {31'd0, wb_valid}, 32'd0);
    check_val("mid_rst_data", wb_data, 32'd0);
    check_val("mid_rst_count", {29'd0, count}, 32'd0);
    check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_val("mid_rst_dat1", ALU_dat1, 32'd0);
    check_val("mid_rst_instr", {26'd0, Instruction_from_CU}, 32'd0);
    repeat (2) @(negedge soc_clk);
    reset_n = 1'b1;
    @(negedge soc_clk);
    push_op(6'd27, 32'd40, 32'd2, 5'd12);
    wait_drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
